// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory request/response bus, branch redirect,
// and the fetch-to-decode handshake, bundled for the fetch stage.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_err;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_err,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           inst_ready
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_err,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC, credit-limited imem requests, in-order instruction
// FIFO towards decode, redirect flush with squashing of in-flight responses.
// Optional macro IF_MISALIGN_CHECK_EN: a redirect to a non-word-aligned
// target raises a sticky misalign_err and halts fetching until the next
// aligned redirect. Without it the target's low two bits are ignored.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  localparam int          PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W  = PTR_W + 1;
  // Stale responses can pile up over back-to-back redirects, so the drop
  // counter gets headroom beyond a single FIFO's worth.
  localparam int          DROP_W = CNT_W + 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [31:0]       fpc;
  logic [31:0]       rpc;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  count;
  logic [DROP_W-1:0] drop;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [31:0]       fifo_inst [FIFO_DEPTH];
  logic [31:0]       fifo_pc   [FIFO_DEPTH];

  logic [31:0]       tgt;
  logic              halted;
  logic              fire;
  logic              push;
  logic              pop;
  logic              drop_hit;
  logic [DROP_W-1:0] drop_sum;
  logic [DROP_W-1:0] drop_redir;
  logic [CNT_W:0]    credit_used;

`ifdef IF_MISALIGN_CHECK_EN
  logic tgt_bad;
  logic misalign;

  assign tgt     = bus.redirect_pc;
  assign tgt_bad = |bus.redirect_pc[1:0];

  // Sticky misalignment flag and fetch halt, re-evaluated on every redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      halted   <= 1'b0;
      misalign <= 1'b0;
    end else if (bus.redirect_valid) begin
      halted   <= tgt_bad;
      misalign <= tgt_bad;
    end
  end

  assign bus.misalign_err = misalign;
`else
  assign tgt              = bus.redirect_pc & 32'hFFFF_FFFC;
  assign halted           = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  // A request may only go out if its response is guaranteed a FIFO slot
  assign credit_used  = {1'b0, outst} + {1'b0, count};
  assign bus.imem_req = !rst && !bus.redirect_valid && !halted &&
                        (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign bus.imem_addr = fpc;

  assign fire     = bus.imem_req && bus.imem_gnt;
  assign drop_hit = bus.imem_rvalid && (drop != '0);
  assign push     = bus.imem_rvalid && (drop == '0) && (outst != '0) &&
                    !bus.redirect_valid;
  assign pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

  // On redirect every in-flight request becomes a drop, including one granted
  // this very cycle; a response arriving this cycle retires one of them.
  assign drop_sum   = drop + DROP_W'(outst) + DROP_W'(bus.imem_gnt);
  assign drop_redir = drop_sum - DROP_W'(bus.imem_rvalid && (drop_sum != '0));

  // Fetch/response PCs, credit counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc    <= RESET_PC;
      rpc    <= RESET_PC;
      outst  <= '0;
      count  <= '0;
      drop   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect_valid) begin
      fpc    <= tgt;
      rpc    <= tgt;
      outst  <= '0;
      count  <= '0;
      drop   <= drop_redir;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (fire)     fpc    <= fpc + 32'd4;
      if (push)     rpc    <= rpc + 32'd4;
      if (drop_hit) drop   <= drop - DROP_W'(1);
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      outst <= outst + CNT_W'(fire) - CNT_W'(push);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO payload storage; contents are only meaningful below count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= rpc;
    end
  end

  assign bus.inst_valid = !rst && (count != '0);
  assign bus.inst       = bus.inst_valid ? fifo_inst[rd_ptr] : NOP;
  assign bus.inst_pc    = bus.inst_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a queue-based scoreboard. Each test
// pushes the PCs decode must receive; a monitor pops one per accepted
// instruction and compares PC and instruction word.
module tb_inst_fetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if bus();

  inst_fetch #(
    .RESET_PC   (32'h0000_0100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] resp_q [$];
  int          budget    = 0;
  int          grants    = 0;
  logic        hold      = 1'b0;
  logic        force_gnt = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, answer the request.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] tpc);
    @(negedge clk);
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = tpc;
    if (!hold && resp_q.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word_of(resp_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    bus.imem_gnt = force_gnt || (bus.imem_req && budget > 0);
    if (bus.imem_gnt) resp_q.push_back(bus.imem_addr);
    if (bus.imem_req && bus.imem_gnt) begin
      grants++;
      budget--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    resp_q.delete();
    exp_q.delete();
    hold = 1'b0; force_gnt = 1'b0; budget = 0; grants = 0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req",      32'(bus.imem_req),     32'h0);
    check("rst_valid",    32'(bus.inst_valid),   32'h0);
    check("rst_inst",     bus.inst,              NOP);
    check("rst_pc",       bus.inst_pc,           32'h0);
    check("rst_misalign", 32'(bus.misalign_err), 32'h0);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (8) cyc(1'b1, 1'b0, 32'h0);
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  // Scoreboard monitor: one comparison per instruction accepted by decode
  initial begin
    logic [31:0] pc_e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %h inst %h expected nothing", bus.inst_pc, bus.inst);
        end else begin
          pc_e = exp_q.pop_front();
          check("out_pc",   bus.inst_pc, pc_e);
          check("out_inst", bus.inst,    word_of(pc_e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Streaming fetch from the reset PC
    do_reset();
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    budget = 4;
    cyc(1'b1, 1'b0, 32'h0);
    check("t1_req_a",  32'(bus.imem_req), 32'h1);
    check("t1_addr_a", bus.imem_addr, 32'h100);
    cyc(1'b1, 1'b0, 32'h0);
    check("t1_addr_b",  bus.imem_addr, 32'h104);
    check("t1_valid_b", 32'(bus.inst_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    check("t1_addr_c",  bus.imem_addr, 32'h108);
    check("t1_valid_c", 32'(bus.inst_valid), 32'h1);
    cyc(1'b1, 1'b0, 32'h0);
    check("t1_addr_d", bus.imem_addr, 32'h10C);
    drain("t1_drained");

    // Backpressure fills exactly DEPTH credits, then release
    do_reset();
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    budget = 100;
    repeat (6) cyc(1'b0, 1'b0, 32'h0);
    check("t2_grants",   32'(grants), 32'(DEPTH));
    check("t2_req_full", 32'(bus.imem_req), 32'h0);
    budget = 1;
    cyc(1'b1, 1'b0, 32'h0);
    check("t2_req_pop_cycle", 32'(bus.imem_req), 32'h0);
    drain("t2_drained");

    // Redirect with two requests outstanding and one buffered
    do_reset();
    exp_q = '{32'h200, 32'h204};
    budget = 3;
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    hold = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    check("t3_buffered", 32'(bus.inst_valid), 32'h1);
    cyc(1'b0, 1'b1, 32'h200);
    check("t3_req_redir", 32'(bus.imem_req), 32'h0);
    hold = 1'b0;
    budget = 2;
    cyc(1'b1, 1'b0, 32'h0);
    check("t3_flushed", 32'(bus.inst_valid), 32'h0);
    check("t3_addr",    bus.imem_addr, 32'h200);
    drain("t3_drained");

    // Redirect coinciding with a grant and a response
    do_reset();
    exp_q = '{32'h300};
    budget = 1;
    cyc(1'b1, 1'b0, 32'h0);
    force_gnt = 1'b1;
    cyc(1'b1, 1'b1, 32'h300);
    force_gnt = 1'b0;
    budget = 1;
    cyc(1'b1, 1'b0, 32'h0);
    check("t4_req",  32'(bus.imem_req), 32'h1);
    check("t4_addr", bus.imem_addr, 32'h300);
    drain("t4_drained");

    // PC wraps past the top of the address space
    do_reset();
    exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    budget = 2;
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    check("t5_addr_top",  bus.imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    check("t5_addr_wrap", bus.imem_addr, 32'h0000_0000);
    drain("t5_drained");

    // Misaligned redirect target
    do_reset();
    budget = 1;
`ifdef IF_MISALIGN_CHECK_EN
    exp_q = '{32'h300};
    cyc(1'b1, 1'b1, 32'h202);
    cyc(1'b1, 1'b0, 32'h0);
    check("t6_misalign_set", 32'(bus.misalign_err), 32'h1);
    check("t6_req_halt",     32'(bus.imem_req), 32'h0);
    repeat (3) cyc(1'b1, 1'b0, 32'h0);
    check("t6_still_halted", 32'(bus.imem_req), 32'h0);
    check("t6_sticky",       32'(bus.misalign_err), 32'h1);
    check("t6_no_valid",     32'(bus.inst_valid), 32'h0);
    cyc(1'b1, 1'b1, 32'h300);
    cyc(1'b1, 1'b0, 32'h0);
    check("t6_misalign_clr", 32'(bus.misalign_err), 32'h0);
    check("t6_req_resume",   32'(bus.imem_req), 32'h1);
    check("t6_addr_resume",  bus.imem_addr, 32'h300);
`else
    exp_q = '{32'h200};
    cyc(1'b1, 1'b1, 32'h202);
    cyc(1'b1, 1'b0, 32'h0);
    check("t6_req",      32'(bus.imem_req), 32'h1);
    check("t6_addr",     bus.imem_addr, 32'h200);
    check("t6_misalign", 32'(bus.misalign_err), 32'h0);
`endif
    drain("t6_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
